// File: rtl/pdp_types_pkg.sv
// Shared PDP-8 types: opcode structs, one-hot bit indices, octal op7 patterns
// and bus widths used by the fetch/decode stage, the EU and their benches.
package pdp_types_pkg;

  localparam int ADDR_WIDTH = 12;
  localparam int DATA_WIDTH = 12;
  localparam int MEM_OPS    = 6;
  localparam int OP7_OPS    = 22;

  // Memory-reference one-hot positions follow the 3-bit opcode value.
  localparam int MEM_AND_BIT = 0;
  localparam int MEM_TAD_BIT = 1;
  localparam int MEM_ISZ_BIT = 2;
  localparam int MEM_DCA_BIT = 3;
  localparam int MEM_JMS_BIT = 4;
  localparam int MEM_JMP_BIT = 5;

  localparam int OP7_CLA2_BIT    = 0;
  localparam int OP7_SPA_BIT     = 1;
  localparam int OP7_SMA_BIT     = 2;
  localparam int OP7_SNA_BIT     = 3;
  localparam int OP7_SZA_BIT     = 4;
  localparam int OP7_SZL_BIT     = 5;
  localparam int OP7_SNL_BIT     = 6;
  localparam int OP7_SKP_BIT     = 7;
  localparam int OP7_OSR_BIT     = 8;
  localparam int OP7_HLT_BIT     = 9;
  localparam int OP7_CLA_CLL_BIT = 10;
  localparam int OP7_CLA1_BIT    = 11;
  localparam int OP7_CLL_BIT     = 12;
  localparam int OP7_CIA_BIT     = 13;
  localparam int OP7_CMA_BIT     = 14;
  localparam int OP7_CML_BIT     = 15;
  localparam int OP7_RTR_BIT     = 16;
  localparam int OP7_RAR_BIT     = 17;
  localparam int OP7_RTL_BIT     = 18;
  localparam int OP7_RAL_BIT     = 19;
  localparam int OP7_IAC_BIT     = 20;
  localparam int OP7_NOP_BIT     = 21;

  localparam logic [DATA_WIDTH-1:0] OP7_NOP     = 12'o7000;
  localparam logic [DATA_WIDTH-1:0] OP7_IAC     = 12'o7001;
  localparam logic [DATA_WIDTH-1:0] OP7_RAL     = 12'o7004;
  localparam logic [DATA_WIDTH-1:0] OP7_RTL     = 12'o7006;
  localparam logic [DATA_WIDTH-1:0] OP7_RAR     = 12'o7010;
  localparam logic [DATA_WIDTH-1:0] OP7_RTR     = 12'o7012;
  localparam logic [DATA_WIDTH-1:0] OP7_CML     = 12'o7020;
  localparam logic [DATA_WIDTH-1:0] OP7_CMA     = 12'o7040;
  localparam logic [DATA_WIDTH-1:0] OP7_CIA     = 12'o7041;
  localparam logic [DATA_WIDTH-1:0] OP7_CLL     = 12'o7100;
  localparam logic [DATA_WIDTH-1:0] OP7_CLA1    = 12'o7200;
  localparam logic [DATA_WIDTH-1:0] OP7_CLA_CLL = 12'o7300;
  localparam logic [DATA_WIDTH-1:0] OP7_HLT     = 12'o7402;
  localparam logic [DATA_WIDTH-1:0] OP7_OSR     = 12'o7404;
  localparam logic [DATA_WIDTH-1:0] OP7_SKP     = 12'o7410;
  localparam logic [DATA_WIDTH-1:0] OP7_SNL     = 12'o7420;
  localparam logic [DATA_WIDTH-1:0] OP7_SZL     = 12'o7430;
  localparam logic [DATA_WIDTH-1:0] OP7_SZA     = 12'o7440;
  localparam logic [DATA_WIDTH-1:0] OP7_SNA     = 12'o7450;
  localparam logic [DATA_WIDTH-1:0] OP7_SMA     = 12'o7500;
  localparam logic [DATA_WIDTH-1:0] OP7_SPA     = 12'o7510;
  localparam logic [DATA_WIDTH-1:0] OP7_CLA2    = 12'o7600;

  typedef struct packed {
    logic                  jmp;
    logic                  jms;
    logic                  dca;
    logic                  isz;
    logic                  tad;
    logic                  and_op;
    logic [DATA_WIDTH-1:0] mem_inst_addr;
  } pdp_mem_opcode_s;

  typedef struct packed {
    logic nop;
    logic iac;
    logic ral;
    logic rtl;
    logic rar;
    logic rtr;
    logic cml;
    logic cma;
    logic cia;
    logic cll;
    logic cla1;
    logic cla_cll;
    logic hlt;
    logic osr;
    logic skp;
    logic snl;
    logic szl;
    logic sza;
    logic sna;
    logic sma;
    logic spa;
    logic cla2;
  } pdp_op7_opcode_s;

  typedef enum logic [2:0] {
    IDLE, FETCH, WAIT_INST, IND_FETCH, WAIT_IND, ISSUE, HOLD
  } ifd_state_e;

endpackage

// File: rtl/pdp_inst_decoder.sv
// Combinational PDP-8 word decoder: memory-reference and exact-match op7
// patterns into one-hot structs; IOT and unlisted op7 words flag illegal.
module pdp_inst_decoder
  import pdp_types_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] inst,
  input  logic [4:0]            pc_page,
  output pdp_mem_opcode_s       mem_op,
  output pdp_op7_opcode_s       op7_op,
  output logic                  is_indirect,
  output logic                  illegal
);

  logic [MEM_OPS-1:0]    mem_vec;
  logic [OP7_OPS-1:0]    op7_vec;
  logic [DATA_WIDTH-1:0] eff_addr;

  // Page-relative addressing never carries into the page bits.
  assign eff_addr = inst[7] ? {pc_page, inst[6:0]} : {5'b0, inst[6:0]};

  always_comb begin
    mem_vec     = '0;
    op7_vec     = '0;
    illegal     = 1'b0;
    is_indirect = 1'b0;
    case (inst[11:9])
      3'o0: mem_vec[MEM_AND_BIT] = 1'b1;
      3'o1: mem_vec[MEM_TAD_BIT] = 1'b1;
      3'o2: mem_vec[MEM_ISZ_BIT] = 1'b1;
      3'o3: mem_vec[MEM_DCA_BIT] = 1'b1;
      3'o4: mem_vec[MEM_JMS_BIT] = 1'b1;
      3'o5: mem_vec[MEM_JMP_BIT] = 1'b1;
      3'o7: begin
        case (inst)
          OP7_NOP:     op7_vec[OP7_NOP_BIT]     = 1'b1;
          OP7_IAC:     op7_vec[OP7_IAC_BIT]     = 1'b1;
          OP7_RAL:     op7_vec[OP7_RAL_BIT]     = 1'b1;
          OP7_RTL:     op7_vec[OP7_RTL_BIT]     = 1'b1;
          OP7_RAR:     op7_vec[OP7_RAR_BIT]     = 1'b1;
          OP7_RTR:     op7_vec[OP7_RTR_BIT]     = 1'b1;
          OP7_CML:     op7_vec[OP7_CML_BIT]     = 1'b1;
          OP7_CMA:     op7_vec[OP7_CMA_BIT]     = 1'b1;
          OP7_CIA:     op7_vec[OP7_CIA_BIT]     = 1'b1;
          OP7_CLL:     op7_vec[OP7_CLL_BIT]     = 1'b1;
          OP7_CLA1:    op7_vec[OP7_CLA1_BIT]    = 1'b1;
          OP7_CLA_CLL: op7_vec[OP7_CLA_CLL_BIT] = 1'b1;
          OP7_HLT:     op7_vec[OP7_HLT_BIT]     = 1'b1;
          OP7_OSR:     op7_vec[OP7_OSR_BIT]     = 1'b1;
          OP7_SKP:     op7_vec[OP7_SKP_BIT]     = 1'b1;
          OP7_SNL:     op7_vec[OP7_SNL_BIT]     = 1'b1;
          OP7_SZL:     op7_vec[OP7_SZL_BIT]     = 1'b1;
          OP7_SZA:     op7_vec[OP7_SZA_BIT]     = 1'b1;
          OP7_SNA:     op7_vec[OP7_SNA_BIT]     = 1'b1;
          OP7_SMA:     op7_vec[OP7_SMA_BIT]     = 1'b1;
          OP7_SPA:     op7_vec[OP7_SPA_BIT]     = 1'b1;
          OP7_CLA2:    op7_vec[OP7_CLA2_BIT]    = 1'b1;
          default: begin
            op7_vec[OP7_NOP_BIT] = 1'b1;
            illegal              = 1'b1;
          end
        endcase
      end
      default: begin
        op7_vec[OP7_NOP_BIT] = 1'b1;
        illegal              = 1'b1;
      end
    endcase
    is_indirect = (|mem_vec) & inst[8];
  end

  assign mem_op = {mem_vec, (|mem_vec) ? eff_addr : {DATA_WIDTH{1'b0}}};
  assign op7_op = op7_vec;

endmodule

// File: rtl/instr_fetch_decode.sv
// PDP-8 instruction fetch/decode stage with issue/hold handshake to the EU.
// Define IFD_INDIRECT_EN to resolve indirect memory references here.
module instr_fetch_decode
  import pdp_types_pkg::*;
#(
  parameter int                    RD_TIMEOUT = 32,
  parameter logic [ADDR_WIDTH-1:0] START_ADDR = 12'o0200
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic [ADDR_WIDTH-1:0] PC_value,
  output logic                  rd_req,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic                  rd_valid,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic [ADDR_WIDTH-1:0] base_addr,
  output pdp_mem_opcode_s       pdp_mem_opcode,
  output pdp_op7_opcode_s       pdp_op7_opcode,
  output logic                  illegal_inst
);

  localparam int TMO_W = $clog2(RD_TIMEOUT) + 1;

  ifd_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  pdp_mem_opcode_s       mem_q, mem_d;
  pdp_op7_opcode_s       op7_q, op7_d;
  logic                  illegal_q, illegal_d;
  logic [TMO_W-1:0]      tmo_q, tmo_d;

  pdp_mem_opcode_s dec_mem;
  pdp_op7_opcode_s dec_op7;
  logic            dec_ind, dec_illegal, ind_go, tmo_done;

  // rd_addr_q still holds the instruction's PC while WAIT_INST decodes it.
  pdp_inst_decoder u_dec (
    .inst        (rd_data),
    .pc_page     (rd_addr_q[ADDR_WIDTH-1 -: 5]),
    .mem_op      (dec_mem),
    .op7_op      (dec_op7),
    .is_indirect (dec_ind),
    .illegal     (dec_illegal)
  );

`ifdef IFD_INDIRECT_EN
  assign ind_go = dec_ind;
`else
  logic unused_ind;
  assign unused_ind = dec_ind;
  assign ind_go     = 1'b0;
`endif

  assign tmo_done = (tmo_q == TMO_W'(RD_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      rd_addr_q <= '0;
      mem_q     <= '0;
      op7_q     <= '0;
      illegal_q <= 1'b0;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_d;
      rd_addr_q <= rd_addr_d;
      mem_q     <= mem_d;
      op7_q     <= op7_d;
      illegal_q <= illegal_d;
      tmo_q     <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (!stall) state_d = FETCH;
      FETCH:     state_d = WAIT_INST;
      WAIT_INST: begin
        if (rd_valid)      state_d = ind_go ? IND_FETCH : ISSUE;
        else if (tmo_done) state_d = FETCH;
      end
      IND_FETCH: state_d = WAIT_IND;
      WAIT_IND: begin
        if (rd_valid)      state_d = ISSUE;
        else if (tmo_done) state_d = IND_FETCH;
      end
      ISSUE:     state_d = HOLD;
      HOLD:      if (!stall) state_d = FETCH;
      default:   state_d = IDLE;
    endcase
  end

  // Decoded fields are captured into holding registers; the output process
  // exposes them only during ISSUE/HOLD.
  always_comb begin
    rd_addr_d = rd_addr_q;
    mem_d     = mem_q;
    op7_d     = op7_q;
    illegal_d = illegal_q;
    tmo_d     = tmo_q;
    case (state_q)
      IDLE, HOLD: if (!stall) rd_addr_d = PC_value;
      FETCH, IND_FETCH: tmo_d = '0;
      WAIT_INST: begin
        if (rd_valid) begin
          mem_d     = dec_mem;
          op7_d     = dec_op7;
          illegal_d = dec_illegal;
          if (ind_go) rd_addr_d = ADDR_WIDTH'(dec_mem.mem_inst_addr);
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      WAIT_IND: begin
        if (rd_valid) mem_d.mem_inst_addr = rd_data;
        else          tmo_d = tmo_q + 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    rd_req         = (state_q == FETCH) || (state_q == IND_FETCH);
    rd_addr        = rd_addr_q;
    base_addr      = START_ADDR;
    pdp_mem_opcode = '0;
    pdp_op7_opcode = '0;
    illegal_inst   = 1'b0;
    if (state_q == ISSUE || state_q == HOLD) begin
      pdp_mem_opcode = mem_q;
      pdp_op7_opcode = op7_q;
    end
    if (state_q == ISSUE) illegal_inst = illegal_q;
  end

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Scoreboard bench: driver pushes expected issues/read addresses, a memory
// responder and an issue monitor pop and compare independently.
module tb_instr_fetch_decode;
  import pdp_types_pkg::*;

  localparam int RD_TIMEOUT = 32;
`ifdef IFD_INDIRECT_EN
  localparam bit IND_ON = 1'b1;
`else
  localparam bit IND_ON = 1'b0;
`endif

  typedef struct {
    logic [5:0]  mem_oh;
    logic [11:0] maddr;
    logic [21:0] op7_oh;
    logic        ill;
    bit          has_ind;
    logic [11:0] ea;
  } exp_t;

  logic clk = 1'b0;
  logic reset, stall, rd_req, rd_valid, illegal_inst;
  logic [11:0] PC_value, rd_addr, rd_data, base_addr;
  pdp_mem_opcode_s mem_op;
  pdp_op7_opcode_s op7_op;

  int checks = 0;
  int errors = 0;
  int withhold = 0;
  bit late_req = 1'b0;
  logic [11:0] mem [4096];
  exp_t exp_q[$];
  logic [11:0] rd_exp_q[$];
  int op7_codes[22] = '{'o7600, 'o7510, 'o7500, 'o7450, 'o7440, 'o7430, 'o7420,
                        'o7410, 'o7404, 'o7402, 'o7300, 'o7200, 'o7100, 'o7041,
                        'o7040, 'o7020, 'o7012, 'o7010, 'o7006, 'o7004, 'o7001,
                        'o7000};

  instr_fetch_decode #(.RD_TIMEOUT(RD_TIMEOUT), .START_ADDR(12'o0200)) dut (
    .clk(clk), .reset(reset), .stall(stall), .PC_value(PC_value),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
    .base_addr(base_addr), .pdp_mem_opcode(mem_op), .pdp_op7_opcode(op7_op),
    .illegal_inst(illegal_inst)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0o expected %0o", name, act, exp);
    end
  endtask

  function automatic logic outs_nz();
    return (mem_op != '0) || (op7_op != '0);
  endfunction

  // Reference model straight from the ISA description.
  function automatic exp_t model(input int word, input int pc);
    exp_t e;
    int op, off, ea, idx;
    e = '{mem_oh: '0, maddr: '0, op7_oh: '0, ill: 1'b0, has_ind: 1'b0, ea: '0};
    op = word / 512;
    if (op <= 5) begin
      off = word % 128;
      ea  = ((word / 128) % 2 == 1) ? (pc / 128) * 128 + off : off;
      e.mem_oh  = 6'(1 << op);
      e.ea      = 12'(ea);
      e.has_ind = IND_ON && ((word / 256) % 2 == 1);
      e.maddr   = e.has_ind ? mem[ea] : 12'(ea);
    end else begin
      idx = -1;
      if (op == 7)
        for (int i = 0; i < 22; i++) if (op7_codes[i] == word) idx = i;
      if (idx < 0) begin
        e.op7_oh = 22'(1) << 21;
        e.ill    = 1'b1;
      end else begin
        e.op7_oh = 22'(1) << idx;
      end
    end
    return e;
  endfunction

  // Memory responder: one outstanding read, random 1..3 cycle latency.
  initial begin
    int tick = 0, due = 0, req_tick = 0;
    bit pend = 0, retry = 0;
    logic [11:0] pdata = '0;
    rd_valid = 1'b0;
    rd_data  = '0;
    forever begin
      @(posedge clk); #1;
      tick++;
      rd_valid = 1'b0;
      if (reset) begin
        pend = 0; retry = 0;
        continue;
      end
      if (late_req) begin
        rd_valid = 1'b1; rd_data = 12'o1205; late_req = 1'b0;
      end else if (pend && tick == due) begin
        rd_valid = 1'b1; rd_data = pdata; pend = 0;
      end
      if (rd_req) begin
        if (rd_exp_q.size() == 0) chk("rd_unexpected", 1, 0);
        else chk("rd_addr", rd_addr, rd_exp_q.pop_front());
        if (retry) begin
          chk("retry_gap", tick - req_tick, RD_TIMEOUT + 1);
          retry = 0;
        end
        if (withhold > 0) begin
          withhold--; retry = 1; req_tick = tick;
        end else begin
          pend = 1; due = tick + $urandom_range(1, 3); pdata = mem[rd_addr];
        end
      end
    end
  end

  // Issue monitor: pops one expectation per new issue, checks every
  // cycle the opcodes are presented.
  initial begin
    bit prev = 0, first, nz;
    exp_t e;
    logic [17:0] mv;
    logic [21:0] ov;
    e = '{mem_oh: '0, maddr: '0, op7_oh: '0, ill: 1'b0, has_ind: 1'b0, ea: '0};
    forever begin
      @(negedge clk);
      if (reset) begin prev = 0; continue; end
      mv = mem_op;
      ov = op7_op;
      nz = (mv != '0) || (ov != '0);
      if (nz) begin
        first = !prev;
        if (first) begin
          if (exp_q.size() == 0) chk("unexpected_issue", 1, 0);
          else e = exp_q.pop_front();
        end
        chk("mem_onehot", mv[17:12], e.mem_oh);
        chk("mem_inst_addr", mv[11:0], e.maddr);
        chk("op7_onehot", ov, e.op7_oh);
        chk("illegal_inst", illegal_inst, first ? e.ill : 1'b0);
        chk("onehot_count", $countones({mv[17:12], ov}), 1);
      end else begin
        chk("illegal_idle", illegal_inst, 0);
      end
      prev = nz;
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    rd_exp_q.delete();
    withhold = 0;
  endtask

  // Called at a negedge with stall=1; returns at a negedge with stall=1.
  task automatic run_inst(input logic [11:0] word, input logic [11:0] pc,
                          input int hold, input bit wh);
    exp_t e;
    bit got = 0;
    mem[pc] = word;
    e = model(word, pc);
    exp_q.push_back(e);
    rd_exp_q.push_back(pc);
    if (wh) begin rd_exp_q.push_back(pc); withhold = 1; end
    if (e.has_ind) rd_exp_q.push_back(e.ea);
    PC_value = pc;
    stall = 1'b0;
    @(posedge clk); #1;
    chk("cleared", outs_nz(), 0);
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (outs_nz()) begin got = 1; break; end
    end
    stall = 1'b1;
    if (!got) begin
      chk("issue_timeout", 0, 1);
      do_reset();
      return;
    end
    repeat (hold) begin
      @(negedge clk);
      chk("held", outs_nz(), 1);
    end
  endtask

  initial begin
    int cat;
    logic [11:0] w;
    for (int i = 0; i < 4096; i++) mem[i] = 12'($urandom);
    reset = 1'b1; stall = 1'b1; PC_value = '0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("rst_rd_req", rd_req, 0);
      chk("rst_rd_addr", rd_addr, 0);
      chk("rst_outs", {mem_op, op7_op, illegal_inst}, 0);
    end
    chk("base_addr", base_addr, 12'o0200);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("idle_no_req", rd_req, 0);
    end

    run_inst(12'o1205, 12'o0200, 10, 0);
    run_inst(12'o1377, 12'o0200, 3, 0);
    run_inst(12'o7300, 12'o0200, 2, 0);
    run_inst(12'o7402, 12'o0200, 2, 0);
    run_inst(12'o6001, 12'o0200, 2, 0);
    mem[12'o0010] = 12'o3456;
    run_inst(12'o1410, 12'o0200, 2, 0);
    run_inst(12'o1205, 12'o0200, 2, 1);

    // Reset while waiting for the instruction word, then a stray rd_valid.
    mem[12'o0300] = 12'o1205;
    rd_exp_q.push_back(12'o0300);
    withhold = 1;
    PC_value = 12'o0300;
    stall = 1'b0;
    @(negedge clk);
    stall = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    late_req = 1'b1;
    repeat (8) begin
      @(negedge clk);
      chk("post_reset_rd_req", rd_req, 0);
      chk("post_reset_outs", {mem_op, op7_op, illegal_inst}, 0);
    end
    chk("post_reset_rd_q", rd_exp_q.size(), 0);

    for (int n = 0; n < 40; n++) begin
      cat = $urandom_range(0, 99);
      if (cat < 40)      w = 12'($urandom_range(0, 'o5777));
      else if (cat < 70) w = 12'(op7_codes[$urandom_range(0, 21)]);
      else if (cat < 85) w = 12'('o7000 + $urandom_range(0, 511));
      else               w = 12'('o6000 + $urandom_range(0, 511));
      run_inst(w, 12'($urandom_range(0, 4095)), $urandom_range(1, 5), 0);
    end

    repeat (4) @(negedge clk);
    chk("exp_q_drained", exp_q.size(), 0);
    chk("rd_q_drained", rd_exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
